// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the UART receiver and transmitter: queues received bytes and
// launches each into the transmitter with a one-cycle pulse, one byte per frame.
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_wr_byte,
  input  logic              i_wr_stb,
  input  logic              i_tx_active,
  input  logic              i_tx_done,
  output logic [7:0]        o_tx_byte,
  output logic              o_tx_dv,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow,
  input  logic              i_clr_overflow
);

  typedef enum logic [1:0] {IDLE, START, BUSY} state_e;

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  state_e              state_q, state_d;
  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic                overflow_q, overflow_d;
  logic                tx_dv_q, tx_dv_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                pop, wr_en, drop;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    tx_byte_d  = tx_byte_q;

    pop   = (state_q == IDLE) && (count_q != '0) && !i_tx_active;
    // A write into a full FIFO lands in the slot the same-edge pop frees.
    wr_en = i_wr_stb && (!full_q || pop);
    drop  = i_wr_stb && full_q && !pop;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      tx_byte_d = mem_q[rd_ptr_q];
    end

    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
    tx_dv_d = pop;

    if (drop)                overflow_d = 1'b1;
    else if (i_clr_overflow) overflow_d = 1'b0;

    case (state_q)
      IDLE:    if (pop) state_d = START;
      START: begin
        if (i_tx_done)        state_d = IDLE;
        else if (i_tx_active) state_d = BUSY;
      end
      BUSY:    if (i_tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_wr_byte;
  end

  assign o_tx_byte  = tx_byte_q;
  assign o_tx_dv    = tx_dv_q;
  assign o_count    = count_q;
  assign o_empty    = empty_q;
  assign o_full     = full_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a transmitter model and a byte scoreboard
// checked at every launch pulse.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [7:0]        i_wr_byte = '0;
  logic              i_wr_stb = 1'b0;
  logic              i_tx_active = 1'b0;
  logic              i_tx_done = 1'b0;
  logic              i_clr_overflow = 1'b0;
  logic [7:0]        o_tx_byte;
  logic              o_tx_dv;
  logic [ADDR_W:0]   o_count;
  logic              o_empty, o_full, o_overflow;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];
  int frame_len = 10;
  int tx_rem = 0;
  bit hold = 1'b0;
  bit prev_dv = 1'b0;
  int launches = 0;
  int dones = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_byte(i_wr_byte), .i_wr_stb(i_wr_stb),
    .i_tx_active(i_tx_active), .i_tx_done(i_tx_done), .o_tx_byte(o_tx_byte),
    .o_tx_dv(o_tx_dv), .o_count(o_count), .o_empty(o_empty), .o_full(o_full),
    .o_overflow(o_overflow), .i_clr_overflow(i_clr_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Launch monitor first, then transmitter model, so both see the same sample.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      tx_rem = 0; i_tx_active = 1'b0; i_tx_done = 1'b0; prev_dv = 1'b0;
    end else begin
      if (o_tx_dv) begin
        launches++;
        chk("dv_single_cycle", {31'b0, prev_dv}, 32'd0);
        chk("launch_while_tx_busy", tx_rem, 32'd0);
        chk("launch_expected", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) chk("tx_byte_order", {24'b0, o_tx_byte}, {24'b0, sb.pop_front()});
      end
      prev_dv = o_tx_dv;
      i_tx_done = 1'b0;
      if (tx_rem > 0) begin
        tx_rem--;
        if (tx_rem == 0) begin i_tx_done = 1'b1; i_tx_active = 1'b0; dones++; end
      end else if (o_tx_dv) begin
        tx_rem = frame_len; i_tx_active = 1'b1;
      end else begin
        i_tx_active = hold;
      end
    end
  end

  task automatic do_wr(input logic [7:0] b, input bit push);
    i_wr_stb = 1'b1; i_wr_byte = b;
    if (push) sb.push_back(b);
    @(negedge i_clk);
    i_wr_stb = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (!(sb.size() == 0 && tx_rem == 0 && o_empty && !hold) && n < budget) begin
      @(negedge i_clk); n++;
    end
    chk(tag, {31'b0, n < budget}, 32'd1);
    repeat (3) @(negedge i_clk);
  endtask

  initial begin
    int idx;
    int n;
    repeat (3) @(negedge i_clk);
    chk("rst_count", {27'b0, o_count}, 32'd0);
    chk("rst_empty", {31'b0, o_empty}, 32'd1);
    chk("rst_full", {31'b0, o_full}, 32'd0);
    chk("rst_overflow", {31'b0, o_overflow}, 32'd0);
    chk("rst_dv", {31'b0, o_tx_dv}, 32'd0);
    chk("rst_byte", {24'b0, o_tx_byte}, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Single byte
    frame_len = 10; launches = 0; dones = 0;
    do_wr(8'hA5, 1'b1);
    chk("single_count_after_e0", {27'b0, o_count}, 32'd1);
    chk("single_dv_not_yet", {31'b0, o_tx_dv}, 32'd0);
    @(negedge i_clk);
    chk("single_dv_at_e1", {31'b0, o_tx_dv}, 32'd1);
    chk("single_byte_at_e1", {24'b0, o_tx_byte}, 32'hA5);
    chk("single_count_popped", {27'b0, o_count}, 32'd0);
    @(negedge i_clk);
    chk("single_dv_dropped", {31'b0, o_tx_dv}, 32'd0);
    wait_drain("single_drain", 200);
    chk("single_launches", launches, 32'd1);
    chk("single_dones", dones, 32'd1);
    chk("single_byte_held", {24'b0, o_tx_byte}, 32'hA5);

    // Burst behind a slow transmitter
    frame_len = 2170; launches = 0; dones = 0;
    for (int i = 1; i <= 5; i++) do_wr(8'(i), 1'b1);
    wait_drain("burst_drain", 20000);
    chk("burst_launches", launches, 32'd5);
    chk("burst_dones", dones, 32'd5);
    chk("burst_final_count", {27'b0, o_count}, 32'd0);

    // Overflow with transmitter held busy
    frame_len = 8; launches = 0; hold = 1'b1;
    repeat (2) @(negedge i_clk);
    for (int i = 0; i < DEPTH; i++) do_wr(8'(8'hC0 + i), 1'b1);
    chk("ovf_full", {31'b0, o_full}, 32'd1);
    chk("ovf_count_depth", {27'b0, o_count}, DEPTH);
    chk("ovf_not_yet", {31'b0, o_overflow}, 32'd0);
    i_clr_overflow = 1'b1;
    do_wr(8'hEE, 1'b0);
    i_clr_overflow = 1'b0;
    chk("ovf_set_wins_over_clear", {31'b0, o_overflow}, 32'd1);
    do_wr(8'hEF, 1'b0);
    chk("ovf_count_unchanged", {27'b0, o_count}, DEPTH);
    hold = 1'b0;
    wait_drain("ovf_drain", 2000);
    chk("ovf_launches", launches, DEPTH);
    chk("ovf_sticky", {31'b0, o_overflow}, 32'd1);
    i_clr_overflow = 1'b1;
    @(negedge i_clk);
    i_clr_overflow = 1'b0;
    chk("ovf_cleared", {31'b0, o_overflow}, 32'd0);

    // Full with simultaneous pop
    launches = 0; hold = 1'b1;
    repeat (2) @(negedge i_clk);
    for (int i = 0; i < DEPTH; i++) do_wr(8'(8'h80 + i), 1'b1);
    chk("fullpop_full", {31'b0, o_full}, 32'd1);
    @(posedge i_clk);
    #1 hold = 1'b0;
    @(negedge i_clk);
    do_wr(8'h77, 1'b1);
    chk("fullpop_launch", {31'b0, o_tx_dv}, 32'd1);
    chk("fullpop_count", {27'b0, o_count}, DEPTH);
    chk("fullpop_no_overflow", {31'b0, o_overflow}, 32'd0);
    wait_drain("fullpop_drain", 2000);
    chk("fullpop_launches", launches, DEPTH + 1);

    // Wrap-around stream at about half occupancy
    frame_len = 4; launches = 0; idx = 0; n = 0;
    while (idx < 3 * DEPTH + 3 && n < 5000) begin
      if (o_count < DEPTH / 2) begin do_wr(8'(8'h40 + idx), 1'b1); idx++; end
      else @(negedge i_clk);
      n++;
    end
    chk("wrap_stream_done", idx, 3 * DEPTH + 3);
    wait_drain("wrap_drain", 2000);
    chk("wrap_launches", launches, 3 * DEPTH + 3);

    // Async reset in the middle of a frame
    frame_len = 2170; launches = 0; n = 0;
    for (int i = 0; i < 6; i++) do_wr(8'(8'h10 + i), 1'b1);
    while (!(i_tx_active && o_count == 5) && n < 100) begin @(negedge i_clk); n++; end
    chk("arst_reached_busy", {31'b0, n < 100}, 32'd1);
    repeat (3) @(negedge i_clk);
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_count", {27'b0, o_count}, 32'd0);
    chk("arst_empty", {31'b0, o_empty}, 32'd1);
    chk("arst_dv", {31'b0, o_tx_dv}, 32'd0);
    chk("arst_byte", {24'b0, o_tx_byte}, 32'd0);
    sb.delete();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    frame_len = 8;
    @(negedge i_clk);
    launches = 0;
    do_wr(8'h3C, 1'b1);
    wait_drain("arst_drain", 500);
    chk("arst_launches", launches, 32'd1);
    chk("arst_byte_after", {24'b0, o_tx_byte}, 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
